// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time arbiter sharing a single-port memory between fetch (if_*) and load/store (d_*) requesters, driving mem_* and returning rvalid/rdata, busy outside IDLE
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int MAX_SKIP = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [2:0] LAT_M1   = 3'(MEM_LAT - 1);
    localparam logic [3:0] SKIP_MAX = 4'(MAX_SKIP);
    state_t state_q, state_d;
    logic [3:0] skip_cnt_q, skip_cnt_d;
    logic [2:0] cnt_q, cnt_d;
    logic owner_q, owner_d;
    logic we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic d_win, i_win;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            skip_cnt_q <= '0;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
    always_comb begin
        d_win      = d_req && (!if_req || skip_cnt_q != SKIP_MAX);
        i_win      = if_req && !d_win;
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: if (d_win || i_win) begin
                state_d    = ACCESS;
                owner_d    = d_win;
                addr_d     = d_win ? d_addr : if_addr;
                we_d       = d_win && d_we;
                wdata_d    = d_win ? d_wdata : '0;
                skip_cnt_d = (d_win && if_req) ? ((skip_cnt_q == SKIP_MAX) ? skip_cnt_q : skip_cnt_q + 4'd1) : 4'd0;
            end
            ACCESS: begin
                state_d = (MEM_LAT > 1) ? WAIT : RESP;
                cnt_d   = LAT_M1;
            end
            WAIT: begin
                state_d = (cnt_q == 3'd1) ? RESP : WAIT;
                cnt_d   = cnt_q - 3'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        if_gnt    = (state_q == IDLE) && i_win;
        d_gnt     = (state_q == IDLE) && d_win;
        mem_en    = state_q == ACCESS;
        mem_we    = mem_en && we_q;
        mem_addr  = mem_en ? addr_q : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        if_rvalid = (state_q == RESP) && !owner_q;
        d_rvalid  = (state_q == RESP) && owner_q;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
        busy      = state_q != IDLE;
    end
endmodule
